// File: rtl/job_dispatcher.sv
// Job sequencer for the duration-timer FSM: one go per accepted job, watchdog/cancel abort with kill hold, cool-down gap.
// go follows the accepting edge by one cycle; req_ready is high only in IDLE, so requests stall for the whole job.
module job_dispatcher #(
   parameter int TIMEOUT     = 120,
   parameter int KILL_CYCLES = 4,
   parameter int GAP         = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             cancel,
   output logic             go,
   output logic             kill,
   input  logic             done,
   output logic             busy,
   output logic             job_ok,
   output logic             job_aborted,
   output logic [CNT_W-1:0] ok_count,
   output logic [CNT_W-1:0] abort_count
);

   localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int HMAX = (KILL_CYCLES > GAP) ? KILL_CYCLES : GAP;
   localparam int HW   = $clog2(HMAX + 1);

   localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [HW-1:0]    KILL_LAST  = HW'(KILL_CYCLES - 1);
   localparam logic [HW-1:0]    GAP_LAST   = HW'(GAP - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_KILL,
      S_COOLDOWN
   } state_t;

   state_t           r_state;
   logic [TW-1:0]    r_timer;
   logic [HW-1:0]    r_hold;
   logic             r_go;
   logic             r_kill;
   logic             r_job_ok;
   logic             r_job_aborted;
   logic [CNT_W-1:0] r_ok_count;
   logic [CNT_W-1:0] r_abort_count;

   logic w_accept;
   logic w_abort;

   assign req_ready   = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign go          = r_go;
   assign kill        = r_kill;
   assign job_ok      = r_job_ok;
   assign job_aborted = r_job_aborted;
   assign ok_count    = r_ok_count;
   assign abort_count = r_abort_count;

   assign w_accept = req_valid && req_ready;
   assign w_abort  = cancel || (r_timer == TIMER_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_timer       <= '0;
         r_hold        <= '0;
         r_go          <= 1'b0;
         r_kill        <= 1'b0;
         r_job_ok      <= 1'b0;
         r_job_aborted <= 1'b0;
         r_ok_count    <= '0;
         r_abort_count <= '0;
      end else begin
         r_job_ok      <= 1'b0;
         r_job_aborted <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_LAUNCH;
                  r_go    <= 1'b1;
               end
            end
            S_LAUNCH: begin
               r_go    <= 1'b0;
               r_timer <= '0;
               r_state <= S_WAIT;
            end
            // done wins over a cancel or timeout sampled on the same edge
            S_WAIT: begin
               if (done) begin
                  r_state  <= S_COOLDOWN;
                  r_hold   <= '0;
                  r_job_ok <= 1'b1;
                  if (r_ok_count != CNT_MAX) begin
                     r_ok_count <= r_ok_count + 1'b1;
                  end
               end else if (w_abort) begin
                  r_state <= S_KILL;
                  r_kill  <= 1'b1;
                  r_hold  <= '0;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_KILL: begin
               if (r_hold == KILL_LAST) begin
                  r_state       <= S_COOLDOWN;
                  r_kill        <= 1'b0;
                  r_hold        <= '0;
                  r_job_aborted <= 1'b1;
                  if (r_abort_count != CNT_MAX) begin
                     r_abort_count <= r_abort_count + 1'b1;
                  end
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            S_COOLDOWN: begin
               if (r_hold == GAP_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_go    <= 1'b0;
               r_kill  <= 1'b0;
            end
         endcase
      end
   end

endmodule
